// File: rtl/tone_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tone_sweep_ctrl
//
// Sequencer for the test-tone generator. It steps the frequency select sent to
// frequency_wave_sel through 00 -> 01 -> 10. Each tone is held for a programmed
// number of complete waveform periods. The block also owns the wave-table phase
// accumulator, so tone changes and stops only happen at a phase wrap. That keeps
// the generated waveform continuous.
//
// Ports
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_sample_tick  one-cycle strobe at the audio sample rate
//   i_start        start pulse, honoured only while idle
//   i_stop         stop request, honoured at the next phase wrap
//   i_loop         repeat the sweep forever (latched on start)
//   i_dwell        periods per tone (latched on start, 0 behaves as 1)
//   i_phase_step   phase increment for the current o_freq_sel
//   o_freq_sel     frequency select to frequency_wave_sel
//   o_phase        wave-table address
//   o_phase_valid  one-cycle pulse when o_phase was updated
//   o_busy         high while a sweep is running or waiting to stop
//   o_done         one-cycle pulse when the sweep ends
// ---------------------------------------------------------------------------
module tone_sweep_ctrl #(
  parameter int DWELL_W = 16,
  parameter int PHASE_W = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sample_tick,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_loop,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [PHASE_W-1:0] i_phase_step,
  output logic [1:0]         o_freq_sel,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_phase_valid,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOP_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         freqSel_q, freqSel_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phaseValid_q, phaseValid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DWELL_W-1:0] periodCnt_q, periodCnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               loop_q, loop_d;

  logic [PHASE_W-1:0] stepEff;
  logic [PHASE_W:0]   phaseSum;
  logic               wrap;
  logic [DWELL_W:0]   periodNext;
  logic               lastPeriod;
  logic               finishSweep;

  // Datapath helpers. A zero step would freeze the accumulator, so it is
  // forced to 1. The carry out of the phase adder marks the end of a period.
  always_comb begin
    stepEff    = (i_phase_step == '0) ? {{(PHASE_W-1){1'b0}}, 1'b1} : i_phase_step;
    phaseSum   = {1'b0, phase_q} + {1'b0, stepEff};
    wrap       = phaseSum[PHASE_W];
    periodNext = {1'b0, periodCnt_q} + {{DWELL_W{1'b0}}, 1'b1};
    lastPeriod = (periodNext >= {1'b0, dwell_q});
  end

  // Next-state logic. Everything holds by default, and the two pulse outputs
  // default low. finishSweep collects every way a sweep can end, so the
  // return to idle is described in one place at the bottom.
  always_comb begin
    state_d      = state_q;
    freqSel_d    = freqSel_q;
    phase_d      = phase_q;
    phaseValid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    periodCnt_d  = periodCnt_q;
    dwell_d      = dwell_q;
    loop_d       = loop_q;
    finishSweep  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (i_start) begin
          dwell_d     = (i_dwell == '0) ? {{(DWELL_W-1){1'b0}}, 1'b1} : i_dwell;
          loop_d      = i_loop;
          freqSel_d   = 2'b00;
          periodCnt_d = '0;
          busy_d      = 1'b1;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (i_sample_tick) begin
          phase_d      = phaseSum[PHASE_W-1:0];
          phaseValid_d = 1'b1;
        end
        // A stop that lands on a wrap tick ends the sweep right there. It does
        // not spend a cycle in STOP_WAIT.
        if (i_sample_tick && wrap) begin
          if (i_stop) begin
            finishSweep = 1'b1;
          end else if (!lastPeriod) begin
            periodCnt_d = periodNext[DWELL_W-1:0];
          end else begin
            periodCnt_d = '0;
            case (freqSel_q)
              2'b00:   freqSel_d = 2'b01;
              2'b01:   freqSel_d = 2'b10;
              default: begin
                if (loop_q) freqSel_d = 2'b00;
                else        finishSweep = 1'b1;
              end
            endcase
          end
        end else if (i_stop) begin
          state_d = ST_STOP_WAIT;
        end
      end

      ST_STOP_WAIT: begin
        if (i_sample_tick) begin
          phase_d      = phaseSum[PHASE_W-1:0];
          phaseValid_d = 1'b1;
          if (wrap) finishSweep = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (finishSweep) begin
      state_d     = ST_IDLE;
      freqSel_d   = 2'b00;
      phase_d     = '0;
      periodCnt_d = '0;
      busy_d      = 1'b0;
      done_d      = 1'b1;
    end
  end

  // State and output registers. Reset is synchronous and aborts a running
  // sweep without raising o_done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      freqSel_q    <= 2'b00;
      phase_q      <= '0;
      phaseValid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      periodCnt_q  <= '0;
      dwell_q      <= {{(DWELL_W-1){1'b0}}, 1'b1};
      loop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      freqSel_q    <= freqSel_d;
      phase_q      <= phase_d;
      phaseValid_q <= phaseValid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      periodCnt_q  <= periodCnt_d;
      dwell_q      <= dwell_d;
      loop_q       <= loop_d;
    end
  end

  assign o_freq_sel    = freqSel_q;
  assign o_phase       = phase_q;
  assign o_phase_valid = phaseValid_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_tone_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tone_sweep_ctrl
//
// Bench for tone_sweep_ctrl. The bench also stands in for frequency_wave_sel:
// select 00 gives step 1, 01 gives step 2 and 10 gives step 4. With those
// steps the periods last 1024, 512 and 256 ticks. A short vector table drives
// the step directly so that wraps come quickly. Longer sweeps are run as
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_tone_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic       stop;
  logic       loopIn;
  logic [15:0] dwell;
  logic [9:0] phaseStep;
  logic [9:0] tableStep;
  logic       tableMode;
  logic [1:0] freqSel;
  logic [9:0] phase;
  logic       phaseValid;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       tick;
    logic [9:0] step;
    logic [9:0] expPhase;
    logic       expValid;
    logic       expBusy;
    logic       expDone;
    logic [1:0] expSel;
  } vec_t;

  vec_t vecs[13];

  tone_sweep_ctrl #(.DWELL_W(16), .PHASE_W(10)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sample_tick (tick),
    .i_start       (start),
    .i_stop        (stop),
    .i_loop        (loopIn),
    .i_dwell       (dwell),
    .i_phase_step  (phaseStep),
    .o_freq_sel    (freqSel),
    .o_phase       (phase),
    .o_phase_valid (phaseValid),
    .o_busy        (busy),
    .o_done        (done)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Model of frequency_wave_sel: the step follows the select combinationally.
  always_comb begin
    phaseStep = 10'd1;
    if (tableMode)             phaseStep = tableStep;
    else if (freqSel == 2'b01) phaseStep = 10'd2;
    else if (freqSel == 2'b10) phaseStep = 10'd4;
  end

  // Advance one clock, then settle 1 ns past the edge before sampling.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic t);
    start = s;
    stop  = p;
    tick  = t;
    cycle();
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // Tick every cycle until the sweep ends or maxTicks runs out. Ticks are
  // counted per select value seen before each tick.
  task automatic runSweep(input int maxTicks, output int c0, output int c1,
                          output int c2, output int doneTick, output int doneCnt,
                          output int busyAtDone);
    logic [1:0] selBefore;
    c0 = 0; c1 = 0; c2 = 0; doneTick = -1; doneCnt = 0; busyAtDone = -1;
    for (int t = 1; t <= maxTicks; t++) begin
      selBefore = freqSel;
      applyStimulus(1'b0, 1'b0, 1'b1);
      case (selBefore)
        2'b00:   c0++;
        2'b01:   c1++;
        default: c2++;
      endcase
      if (done) begin
        doneCnt++;
        doneTick   = t;
        busyAtDone = int'(busy);
        break;
      end
    end
  endtask

  task automatic checkOneShot(input string tag, input logic [15:0] dw);
    int c0, c1, c2, dt, dc, bd;
    dwell  = dw;
    loopIn = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({tag, " busy after start"}, int'(busy), 1);
    runSweep(3000, c0, c1, c2, dt, dc, bd);
    checkOutput({tag, " ticks sel00"}, c0, 1024);
    checkOutput({tag, " ticks sel01"}, c1, 512);
    checkOutput({tag, " ticks sel10"}, c2, 256);
    checkOutput({tag, " done tick"}, dt, 1792);
    checkOutput({tag, " busy at done"}, bd, 0);
    checkOutput({tag, " sel at done"}, int'(freqSel), 0);
    checkOutput({tag, " phase at done"}, int'(phase), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput({tag, " done is a pulse"}, int'(done), 0);
  endtask

  initial begin
    int seenValid, seenPhase, seenBusy, doneSeen, ticks, sawSel2;
    int chgTick[$];
    int chgSel[$];
    int expTick[6] = '{2048, 3072, 3584, 5632, 6656, 7168};
    int expSel[6]  = '{1, 2, 0, 1, 2, 0};
    logic [1:0] prevSel;

    // start stop tick step | phase valid busy done sel
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 10'd256,  10'd0,   1'b0, 1'b1, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 10'd256,  10'd256, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 10'd256,  10'd512, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 10'd256,  10'd512, 1'b0, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 10'd256,  10'd768, 1'b1, 1'b1, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 10'd256,  10'd0,   1'b1, 1'b1, 1'b0, 2'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 10'd0,    10'd1,   1'b1, 1'b1, 1'b0, 2'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 10'd1023, 10'd0,   1'b1, 1'b1, 1'b0, 2'd2};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 10'd512,  10'd512, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 10'd512,  10'd512, 1'b0, 1'b1, 1'b0, 2'd2};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 10'd256,  10'd768, 1'b1, 1'b1, 1'b0, 2'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 10'd256,  10'd0,   1'b1, 1'b0, 1'b1, 2'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 10'd256,  10'd0,   1'b0, 1'b0, 1'b0, 2'd0};

    rst = 1'b0; tick = 1'b0; start = 1'b0; stop = 1'b0; loopIn = 1'b0;
    dwell = 16'd1; tableStep = 10'd0; tableMode = 1'b0;

    // Reset values, then 50 ticks with no start.
    doReset();
    checkOutput("reset phase", int'(phase), 0);
    checkOutput("reset sel", int'(freqSel), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset valid", int'(phaseValid), 0);
    seenValid = 0; seenPhase = 0; seenBusy = 0;
    stop = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick = 1'b1;
      cycle();
      if (phaseValid) seenValid++;
      if (phase != 10'd0) seenPhase++;
      if (busy) seenBusy++;
    end
    tick = 1'b0; stop = 1'b0;
    checkOutput("idle valid pulses", seenValid, 0);
    checkOutput("idle phase moves", seenPhase, 0);
    checkOutput("idle busy cycles", seenBusy, 0);

    // Vector table with dwell=1, loop=0 and directly driven steps.
    tableMode = 1'b1; dwell = 16'd1; loopIn = 1'b0;
    for (int i = 0; i < 13; i++) begin
      tableStep = vecs[i].step;
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].tick);
      checkOutput($sformatf("vec%0d phase", i), int'(phase), int'(vecs[i].expPhase));
      checkOutput($sformatf("vec%0d outs", i),
                  int'({phaseValid, busy, done, freqSel}),
                  int'({vecs[i].expValid, vecs[i].expBusy, vecs[i].expDone, vecs[i].expSel}));
    end
    tableMode = 1'b0;

    // Full single sweeps; dwell 0 must behave exactly like dwell 1.
    checkOneShot("dwell1", 16'd1);
    checkOneShot("dwell0", 16'd0);

    // Looping sweep with dwell 2: log every select change over 8000 ticks.
    dwell = 16'd2; loopIn = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    loopIn = 1'b0;
    doneSeen = 0;
    for (int t = 1; t <= 8000; t++) begin
      prevSel = freqSel;
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (done) doneSeen++;
      if (freqSel != prevSel) begin
        chgTick.push_back(t);
        chgSel.push_back(int'(freqSel));
      end
    end
    checkOutput("loop done count", doneSeen, 0);
    checkOutput("loop busy", int'(busy), 1);
    checkOutput("loop change count", chgTick.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < chgTick.size()) begin
        checkOutput($sformatf("loop change%0d tick", i), chgTick[i], expTick[i]);
        checkOutput($sformatf("loop change%0d sel", i), chgSel[i], expSel[i]);
      end
    end
    doReset();
    checkOutput("loop abort busy", int'(busy), 0);

    // Stop at sel=01, phase=200: (1024-200)/2 = 412 more ticks to the wrap.
    dwell = 16'd1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 1124; t++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pre-stop sel", int'(freqSel), 1);
    checkOutput("pre-stop phase", int'(phase), 200);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stop wait busy", int'(busy), 1);
    ticks = -1; sawSel2 = 0;
    for (int t = 1; t <= 1000; t++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (freqSel == 2'b10) sawSel2++;
      if (done) begin
        ticks = t;
        break;
      end
    end
    checkOutput("stop ticks to done", ticks, 412);
    checkOutput("stop sel advanced", sawSel2, 0);
    checkOutput("stop phase", int'(phase), 0);
    checkOutput("stop sel", int'(freqSel), 0);
    checkOutput("stop busy", int'(busy), 0);

    // Start while busy (tick 500) is ignored; stop lands on the wrap tick.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= 1023; t++) applyStimulus(t == 500, 1'b0, 1'b1);
    checkOutput("busy-start phase", int'(phase), 1023);
    checkOutput("busy-start sel", int'(freqSel), 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("wrap-stop done", int'(done), 1);
    checkOutput("wrap-stop busy", int'(busy), 0);
    checkOutput("wrap-stop sel", int'(freqSel), 0);
    checkOutput("wrap-stop phase", int'(phase), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("wrap-stop done pulse", int'(done), 0);

    // Reset in the middle of the sel=10 tone aborts without a done pulse.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 1540; t++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pre-reset sel", int'(freqSel), 2);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    checkOutput("abort outs", int'({phase, phaseValid, busy, done, freqSel}), 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort no done", int'(done), 0);
    checkOutput("abort idle phase", int'(phase), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
